// File: rtl/bomberman_gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bomberman_gfx_pkg
// Description : Shared graphics types and constants for the sprite
//               compositor. Holds the sprite position record, the 16-entry
//               24-bit palette and the background gradient helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bomberman_gfx_pkg;

    // Storage width for sprite coordinates. Instances with a narrower
    // COORD_W zero-extend into this width, so the unused upper bits stay
    // constant zero and synthesis removes them.
    localparam int c_COORD_MAX_W = 16;

    typedef struct packed {
        logic [c_COORD_MAX_W-1:0] x;
        logic [c_COORD_MAX_W-1:0] y;
        logic                     vis;
    } sprite_pos_t;

    // Palette: index -> {R, G, B}
    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
        24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
        24'h000080, 24'hFF8000, 24'h804000, 24'h404040
    };

    // Background blue channel. col is DrawX/8 already truncated to 7 bits;
    // the subtraction wraps modulo 128, matching the 7-bit truncation.
    function automatic logic [7:0] bg_blue(input logic [6:0] col);
        logic [6:0] v_blue;
        v_blue = 7'h7F - col;
        return {1'b0, v_blue};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_pos_regs.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pos_regs
// Description : Double-buffered sprite position/visibility register file.
//               Writes land in the shadow bank; frame_start copies the whole
//               shadow bank into the active bank in one cycle. A write in the
//               same cycle as frame_start is not seen by the copy.
// Ports       : clk, rst          - clock, async active-high reset
//               i_wr_en/i_wr_idx  - shadow write strobe and sprite index
//               i_wr_x/y/vis      - shadow write data
//               i_frame_start     - shadow -> active copy pulse
//               o_active          - active bank, feeds the hit test
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pos_regs
    import bomberman_gfx_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    parameter int IDX_W       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [COORD_W-1:0] i_wr_x,
    input  logic [COORD_W-1:0] i_wr_y,
    input  logic               i_wr_vis,
    input  logic               i_frame_start,
    output sprite_pos_t        o_active [NUM_SPRITES]
);

    sprite_pos_t r_shadow [NUM_SPRITES];
    sprite_pos_t r_active [NUM_SPRITES];
    sprite_pos_t w_wr_entry;

    always_comb begin
        w_wr_entry     = '0;
        w_wr_entry.x   = c_COORD_MAX_W'(i_wr_x);
        w_wr_entry.y   = c_COORD_MAX_W'(i_wr_y);
        w_wr_entry.vis = i_wr_vis;
    end

    // Indices >= NUM_SPRITES never match any entry, so such writes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (i_frame_start) begin
                    r_active[i] <= r_shadow[i];
                end
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_shadow[i] <= w_wr_entry;
                end
            end
        end
    end

    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor
// Description : Three-stage sprite compositor. Stage 1 hit-tests the current
//               pixel against all active sprites (lowest index wins) and
//               registers the ROM address; stage 2 waits for the registered
//               ROM read; stage 3 maps the palette index to RGB or falls back
//               to the background gradient. One pixel per cycle, latency 3.
// Config      : SPRITE_TRANSPARENCY_EN - when defined, palette index 0 is
//               transparent and shows the background.
// Ports       : Clk, Reset                  - clock, async active-high reset
//               wr_en/wr_idx/wr_x/wr_y/wr_vis - shadow sprite write
//               frame_start                 - shadow -> active bank copy
//               DrawX, DrawY, pix_valid_in  - pixel from the VGA controller
//               rom_addr, rom_data          - shared sprite ROM port
//               Red, Green, Blue            - registered pixel colour
//               pix_valid_out, sprite_hit, hit_id - output pixel status
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_compositor
    import bomberman_gfx_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 8,
    parameter int SPRITE_H    = 8,
    parameter int COORD_W     = 10,
    parameter int PIX_W       = 4,
    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int COL_W  = $clog2(SPRITE_W),
    localparam int ROW_W  = $clog2(SPRITE_H),
    localparam int ADDR_W = IDX_W + ROW_W + COL_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               wr_vis,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               pix_valid_in,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIX_W-1:0]   rom_data,
    output logic [7:0]         Red,
    output logic [7:0]         Green,
    output logic [7:0]         Blue,
    output logic               pix_valid_out,
    output logic               sprite_hit,
    output logic [IDX_W-1:0]   hit_id
);

    // One extra bit over the storage width so a pixel left of / above the
    // sprite yields a huge unsigned difference and can never wrap into range.
    localparam int                c_DIFF_W     = c_COORD_MAX_W + 1;
    localparam logic [c_DIFF_W-1:0] c_SPRITE_W_D = c_DIFF_W'(SPRITE_W);
    localparam logic [c_DIFF_W-1:0] c_SPRITE_H_D = c_DIFF_W'(SPRITE_H);

    sprite_pos_t w_active [NUM_SPRITES];

    sprite_pos_regs #(
        .NUM_SPRITES (NUM_SPRITES),
        .COORD_W     (COORD_W),
        .IDX_W       (IDX_W)
    ) u_pos_regs (
        .clk           (Clk),
        .rst           (Reset),
        .i_wr_en       (wr_en),
        .i_wr_idx      (wr_idx),
        .i_wr_x        (wr_x),
        .i_wr_y        (wr_y),
        .i_wr_vis      (wr_vis),
        .i_frame_start (frame_start),
        .o_active      (w_active)
    );

    // ------------------------------------------------------------------
    // Stage 1: hit test. Scanning from the highest index down lets the
    // lowest hitting index overwrite the result last.
    // ------------------------------------------------------------------
    logic [c_DIFF_W-1:0] w_dx;
    logic [c_DIFF_W-1:0] w_dy;
    logic                w_hit;
    logic [IDX_W-1:0]    w_id;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic [6:0]          w_bg_col;

    always_comb begin
        w_dx  = '0;
        w_dy  = '0;
        w_hit = 1'b0;
        w_id  = '0;
        w_col = '0;
        w_row = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            w_dx = {1'b0, c_COORD_MAX_W'(DrawX)} - {1'b0, w_active[i].x};
            w_dy = {1'b0, c_COORD_MAX_W'(DrawY)} - {1'b0, w_active[i].y};
            if (pix_valid_in && w_active[i].vis &&
                (w_dx < c_SPRITE_W_D) && (w_dy < c_SPRITE_H_D)) begin
                w_hit = 1'b1;
                w_id  = IDX_W'(i);
                w_col = w_dx[COL_W-1:0];
                w_row = w_dy[ROW_W-1:0];
            end
        end
    end

    // Only the 7 bits of DrawX/8 that reach the gradient are carried down.
    assign w_bg_col = 7'(DrawX >> 3);

    logic             r_s1_valid;
    logic             r_s1_hit;
    logic [IDX_W-1:0] r_s1_id;
    logic [6:0]       r_s1_col;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_id    <= '0;
            r_s1_col   <= '0;
            rom_addr   <= '0;
        end else begin
            r_s1_valid <= pix_valid_in;
            r_s1_hit   <= w_hit;
            r_s1_id    <= w_id;
            r_s1_col   <= w_bg_col;
            rom_addr   <= w_hit ? {w_id, w_row, w_col} : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align pixel status with the registered ROM read.
    // ------------------------------------------------------------------
    logic             r_s2_valid;
    logic             r_s2_hit;
    logic [IDX_W-1:0] r_s2_id;
    logic [6:0]       r_s2_col;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s2_valid <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_id    <= '0;
            r_s2_col   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_hit   <= r_s1_hit;
            r_s2_id    <= r_s1_id;
            r_s2_col   <= r_s1_col;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: colour resolve.
    // ------------------------------------------------------------------
    logic       w_opaque;
    logic       w_show;
    logic [3:0] w_pal_idx;

`ifdef SPRITE_TRANSPARENCY_EN
    // A transparent pixel falls straight to the background; lower-priority
    // sprites are not re-read since only one ROM access exists per pixel.
    assign w_opaque = (rom_data != '0);
`else
    assign w_opaque = 1'b1;
`endif

    assign w_show    = r_s2_hit && w_opaque;
    assign w_pal_idx = 4'(rom_data);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red           <= '0;
            Green         <= '0;
            Blue          <= '0;
            pix_valid_out <= 1'b0;
            sprite_hit    <= 1'b0;
            hit_id        <= '0;
        end else begin
            pix_valid_out <= r_s2_valid;
            if (!r_s2_valid) begin
                Red        <= '0;
                Green      <= '0;
                Blue       <= '0;
                sprite_hit <= 1'b0;
                hit_id     <= '0;
            end else if (w_show) begin
                {Red, Green, Blue} <= PALETTE[w_pal_idx];
                sprite_hit         <= 1'b1;
                hit_id             <= r_s2_id;
            end else begin
                Red        <= '0;
                Green      <= '0;
                Blue       <= bg_blue(r_s2_col);
                sprite_hit <= 1'b0;
                hit_id     <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_compositor
// Description : Scoreboard bench for sprite_compositor (4 sprites, 8x8,
//               COORD_W = 10). The driver pushes hand-computed expectations;
//               a negedge monitor pops and compares whenever pix_valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

    logic       Clk;
    logic       Reset;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic       wr_vis;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_valid_in;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic       pix_valid_out;
    logic       sprite_hit;
    logic [1:0] hit_id;

    sprite_compositor #(
        .NUM_SPRITES (4),
        .SPRITE_W    (8),
        .SPRITE_H    (8),
        .COORD_W     (10),
        .PIX_W       (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_vis        (wr_vis),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pix_valid_in  (pix_valid_in),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .Red           (Red),
        .Green         (Green),
        .Blue          (Blue),
        .pix_valid_out (pix_valid_out),
        .sprite_hit    (sprite_hit),
        .hit_id        (hit_id)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Sprite ROM with a one-cycle registered read
    logic [3:0] rom_mem [256];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    logic [23:0] tb_pal [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
        24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
        24'h000080, 24'hFF8000, 24'h804000, 24'h404040
    };

    typedef struct {
        logic        hit;
        logic [1:0]  id;
        logic [7:0]  addr;
        logic [23:0] rgb;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] h0 = '0, h1 = '0, h2 = '0;
    exp_t       m_e;

    always @(negedge Clk) begin
        h2 = h1;
        h1 = h0;
        h0 = rom_addr;
        if (pix_valid_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(pix_valid_out), 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("rgb",        {8'h0, Red, Green, Blue}, {8'h0, m_e.rgb});
                check("sprite_hit", 32'(sprite_hit), 32'(m_e.hit));
                check("hit_id",     32'(hit_id), 32'(m_e.id));
                check("rom_addr",   32'(h2), 32'(m_e.addr));
                check("latency",    32'(cyc - m_e.cyc), 32'd3);
            end
        end else if (!Reset) begin
            check("idle_zero", {13'h0, Red, Green, Blue, sprite_hit, hit_id}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(negedge Clk);
        wr_en = 1'b0; frame_start = 1'b0; pix_valid_in = 1'b0;
    endtask

    task automatic wr(input int idx, input int x, input int y, input bit vis, input bit fs);
        @(negedge Clk);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_vis = vis;
        frame_start = fs; pix_valid_in = 1'b0;
    endtask

    task automatic fs();
        @(negedge Clk);
        wr_en = 1'b0; frame_start = 1'b1; pix_valid_in = 1'b0;
    endtask

    task automatic raw(input int x, input int y);
        @(negedge Clk);
        wr_en = 1'b0; frame_start = 1'b0; pix_valid_in = 1'b1;
        DrawX = 10'(x); DrawY = 10'(y);
    endtask

    // hit/id/addr/idx describe the sprite result; blue is the background
    // blue channel expected when the pixel resolves to background.
    task automatic pixel(input int x, input int y, input bit hit, input int id,
                         input int addr, input int idx, input logic [7:0] blue);
        exp_t e;
        raw(x, y);
        e.cyc  = cyc;
        e.hit  = hit;
        e.id   = hit ? 2'(id) : 2'd0;
        e.addr = hit ? 8'(addr) : 8'd0;
        e.rgb  = hit ? tb_pal[idx] : {16'h0, blue};
        if (hit) rom_mem[addr] = 4'(idx);
`ifdef SPRITE_TRANSPARENCY_EN
        if (hit && idx == 0) begin
            e.hit = 1'b0;
            e.id  = 2'd0;
            e.rgb = {16'h0, blue};
        end
`endif
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_vis = 1'b0;
        frame_start = 1'b0; DrawX = '0; DrawY = '0; pix_valid_in = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'h0;
        repeat (3) @(negedge Clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rgb",      {8'h0, Red, Green, Blue}, 32'd0);
        check("rst_valid",    32'(pix_valid_out), 32'd0);
        check("rst_hit",      {30'h0, sprite_hit, 1'b0} | 32'(hit_id), 32'd0);
        Reset = 1'b0;

        // single sprite, basic hit
        wr(0, 100, 50, 1'b1, 1'b0);
        fs();
        pixel(103, 52, 1'b1, 0, 19, 5, 8'h00);

        // overlapping sprites: lowest index wins; edges of the 8x8 box
        wr(1, 200, 200, 1'b1, 1'b0);
        wr(2, 200, 200, 1'b1, 1'b0);
        fs();
        pixel(201, 201, 1'b1, 1, 73, 3, 8'h00);
        pixel(207, 207, 1'b1, 1, 127, 9, 8'h00);
        pixel(208, 201, 1'b0, 0, 0, 0, 8'h65);
        pixel(199, 201, 1'b0, 0, 0, 0, 8'h67);
        pixel(40, 10, 1'b0, 0, 0, 0, 8'h7A);

        // shadow/active banking
        wr(0, 300, 300, 1'b1, 1'b0);
        pixel(300, 300, 1'b0, 0, 0, 0, 8'h5A);
        fs();
        pixel(300, 300, 1'b1, 0, 0, 7, 8'h00);
        wr(0, 500, 500, 1'b1, 1'b1);
        pixel(300, 300, 1'b1, 0, 0, 7, 8'h00);
        pixel(500, 500, 1'b0, 0, 0, 0, 8'h41);
        fs();
        pixel(500, 500, 1'b1, 0, 0, 7, 8'h00);
        pixel(300, 300, 1'b0, 0, 0, 0, 8'h5A);

        // right screen edge: no wrap-around
        wr(3, 1020, 0, 1'b1, 1'b0);
        fs();
        pixel(1023, 3, 1'b1, 3, 219, 0, 8'h00);
        pixel(1020, 0, 1'b1, 3, 192, 13, 8'h00);
        pixel(0, 0, 1'b0, 0, 0, 0, 8'h7F);
        pixel(3, 2, 1'b0, 0, 0, 0, 8'h7F);
        pixel(1019, 0, 1'b0, 0, 0, 0, 8'h00);

        // invisible sprite
        wr(3, 1020, 0, 1'b0, 1'b0);
        fs();
        pixel(1020, 0, 1'b0, 0, 0, 0, 8'h00);

        // reset with pixels in flight
        repeat (5) idle();
        raw(201, 201);
        raw(202, 202);
        raw(203, 203);
        @(posedge Clk);
        #1;
        check("inflight_valid", 32'(pix_valid_out), 32'd1);
        check("inflight_hit",   32'(sprite_hit), 32'd1);
        Reset = 1'b1;
        pix_valid_in = 1'b0;
        #1;
        check("flush_valid",    32'(pix_valid_out), 32'd0);
        check("flush_rgb",      {8'h0, Red, Green, Blue}, 32'd0);
        check("flush_hit",      32'(sprite_hit), 32'd0);
        check("flush_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        pixel(201, 201, 1'b0, 0, 0, 0, 8'h66);
        fs();
        pixel(201, 201, 1'b0, 0, 0, 0, 8'h66);

        repeat (4) idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
